pong_game_ctrl: RTL

//  Game-flow controller and score keeper for Pong. Produces the score digits and the balls-remaining count that the text overlay renders.

---
 rtl/pong_pkg.sv | 14 +
 rtl/bcd2_counter.sv | 33 +++
 rtl/pong_game_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game-flow controller: FSM state encoding
// and score digit width.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam int DIG_W = 4;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter, 00..99 with wrap; clear takes priority over
// increment.
module bcd2_counter
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [DIG_W-1:0] d1,
    output logic [DIG_W-1:0] d0
);

    localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(9);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1 <= '0;
            d0 <= '0;
        end else if (clr) begin
            d1 <= '0;
            d0 <= '0;
        end else if (inc) begin
            if (d0 == DIG_MAX) begin
                d0 <= '0;
                d1 <= (d1 == DIG_MAX) ? '0 : d1 + 1'b1;
            end else begin
                d0 <= d0 + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: start/pause/game-over sequencing, score and
// balls-remaining bookkeeping, and region/freeze enables for graphics.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_NEWGAME | rule text shown, waiting for a button press to start a game
// ST_PLAY    | ball in motion, hits score and misses cost a ball
// ST_NEWBALL | frozen pause after a miss; leave on press once timer expires
// ST_OVER    | "Game Over" shown until the timer expires
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS_INIT  = 3,
    parameter int TIMER_TICKS = 120,
    parameter int TIMER_W     = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       btn,
    input  logic             refr_tick,
    input  logic             hit,
    input  logic             miss,
    output logic [DIG_W-1:0] dig0,
    output logic [DIG_W-1:0] dig1,
    output logic [1:0]       ball,
    output logic             gra_still,
    output logic             rule_en,
    output logic             over_en
);

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMER_TICKS);
    localparam logic [1:0]         BALL_LOAD  = 2'(BALLS_INIT);

    state_t             state, state_next;
    logic [1:0]         ball_next;
    logic [1:0]         btn_q;
    logic [TIMER_W-1:0] timer;
    logic               press;
    logic               timer_done;
    logic               timer_load;
    logic               score_clr;
    logic               score_inc;

    assign press      = |(btn & ~btn_q);
    assign timer_done = (timer == '0);
    assign timer_load = (state_next != state) &&
                        ((state_next == ST_NEWBALL) || (state_next == ST_OVER));

    always_comb begin
        state_next = state;
        ball_next  = ball;
        score_clr  = 1'b0;
        score_inc  = 1'b0;
        case (state)
            ST_NEWGAME: begin
                if (press) begin
                    score_clr  = 1'b1;
                    ball_next  = BALL_LOAD;
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                score_inc = hit;
                if (miss) begin
                    if (ball == 2'd0) begin
                        state_next = ST_OVER;
                    end else begin
                        ball_next  = ball - 1'b1;
                        state_next = ST_NEWBALL;
                    end
                end
            end
            ST_NEWBALL: begin
                // Presses during the pause are dropped, not remembered.
                if (timer_done && press) state_next = ST_PLAY;
            end
            ST_OVER: begin
                if (timer_done) state_next = ST_NEWGAME;
            end
            default: state_next = ST_NEWGAME;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_NEWGAME;
            ball      <= BALL_LOAD;
            btn_q     <= '0;
            timer     <= '0;
            gra_still <= 1'b1;
            rule_en   <= 1'b1;
            over_en   <= 1'b0;
        end else begin
            state     <= state_next;
            ball      <= ball_next;
            btn_q     <= btn;
            if (timer_load) begin
                timer <= TIMER_LOAD;
            end else if (refr_tick && !timer_done) begin
                timer <= timer - 1'b1;
            end
            // Enables track the state being entered so they change with it.
            gra_still <= (state_next != ST_PLAY);
            rule_en   <= (state_next == ST_NEWGAME);
            over_en   <= (state_next == ST_OVER);
        end
    end

    bcd2_counter u_score (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (score_clr),
        .inc     (score_inc),
        .d1      (dig1),
        .d0      (dig0)
    );

endmodule
